// File: rtl/nv_nvdla_pdp_rdma_sched_pkg.sv
// Shared types and command payload layout for the PDP RDMA split scheduler.
package nv_nvdla_pdp_rdma_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam int X_OFFSET_W = 13;
  localparam int WIDTH_W    = 10;
  localparam int IDX_W      = 8;

  localparam int PD_W         = 33;
  localparam int PD_WIDTH_LSB = 0;
  localparam int PD_XOFF_LSB  = 10;
  localparam int PD_IDX_LSB   = 23;
  localparam int PD_FIRST_BIT = 31;
  localparam int PD_LAST_BIT  = 32;

  function automatic logic [PD_W-1:0] pack_cmd_pd(
    input logic                  is_last,
    input logic                  is_first,
    input logic [IDX_W-1:0]      idx,
    input logic [X_OFFSET_W-1:0] x_offset,
    input logic [WIDTH_W-1:0]    width_m1
  );
    logic [PD_W-1:0] pd;
    pd = '0;
    pd[PD_LAST_BIT]                   = is_last;
    pd[PD_FIRST_BIT]                  = is_first;
    pd[PD_IDX_LSB +: IDX_W]           = idx;
    pd[PD_XOFF_LSB +: X_OFFSET_W]     = x_offset;
    pd[PD_WIDTH_LSB +: WIDTH_W]       = width_m1;
    return pd;
  endfunction

endpackage

// File: rtl/nv_nvdla_pdp_rdma_split_sched_if.sv
// Command handshake toward the RDMA ingress plus split completion from the egress.
interface nv_nvdla_pdp_rdma_split_sched_if;
  import nv_nvdla_pdp_rdma_sched_pkg::*;

  logic            sched2ig_cmd_valid;
  logic            sched2ig_cmd_ready;
  logic [PD_W-1:0] sched2ig_cmd_pd;
  logic            eg2sched_split_done;

  modport master (
    output sched2ig_cmd_valid,
    output sched2ig_cmd_pd,
    input  sched2ig_cmd_ready,
    input  eg2sched_split_done
  );

  modport slave (
    input  sched2ig_cmd_valid,
    input  sched2ig_cmd_pd,
    output sched2ig_cmd_ready,
    output eg2sched_split_done
  );
endinterface

// File: rtl/nv_nvdla_pdp_rdma_split_cnt.sv
// Outstanding-split up/down counter with limit compare and sticky underflow error.
module nv_nvdla_pdp_rdma_split_cnt #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_below_lim,
  output logic o_zero,
  output logic o_err
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_underflow;
  logic             w_dec_ok;

  assign o_zero      = (r_cnt == '0);
  assign o_below_lim = (r_cnt < CNT_W'(MAX_OUTSTANDING));
  assign o_err       = r_err;

  // a simultaneous inc cancels the dec, so only a lone dec at zero is an underflow
  assign w_underflow = i_dec && !i_inc && o_zero;
  assign w_dec_ok    = i_dec && !i_inc && !o_zero;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_underflow) r_err <= 1'b1;
      if (i_clr)                r_cnt <= '0;
      else if (i_inc && !i_dec) r_cnt <= r_cnt + CNT_W'(1);
      else if (w_dec_ok)        r_cnt <= r_cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/nv_nvdla_pdp_rdma_split_sched.sv
// PDP RDMA split scheduler: turns one read operation into per-split ingress
// commands, limits splits in flight and pulses op_done once all have returned.
//
// state | meaning
// IDLE  | waiting for reg2dp_op_load
// ISSUE | presenting split commands while below the outstanding limit
// DRAIN | every split issued, waiting for the egress to return them
// DONE  | one-cycle sched_op_done pulse
module nv_nvdla_pdp_rdma_split_sched
  import nv_nvdla_pdp_rdma_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 3
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  input  logic                      reg2dp_op_load,
  input  logic [IDX_W-1:0]          reg2dp_split_num,
  input  logic [X_OFFSET_W-1:0]     reg2dp_cube_in_width,
  input  logic [WIDTH_W-1:0]        reg2dp_partial_width_in_first,
  input  logic [WIDTH_W-1:0]        reg2dp_partial_width_in_mid,
  input  logic [WIDTH_W-1:0]        reg2dp_partial_width_in_last,
  nv_nvdla_pdp_rdma_split_sched_if.master sched_if,
  output logic                      sched_busy,
  output logic                      sched_op_done,
  output logic                      sched_err
);
  sched_state_e          r_state;
  sched_state_e          w_state_nxt;
  logic [IDX_W-1:0]      r_split_num;
  logic [IDX_W-1:0]      r_split_idx;
  logic [WIDTH_W-1:0]    r_cube_w;
  logic [WIDTH_W-1:0]    r_first_w;
  logic [WIDTH_W-1:0]    r_mid_w;
  logic [WIDTH_W-1:0]    r_last_w;
  logic [X_OFFSET_W-1:0] r_x_offset;
  logic                  r_issued_all;

  logic [WIDTH_W-1:0]    w_width_m1;
  logic                  w_load;
  logic                  w_valid;
  logic                  w_hs;
  logic                  w_is_first;
  logic                  w_is_last;
  logic                  w_below_lim;
  logic                  w_zero;
  logic                  w_unused_cube;

  // cube widths above 1023 are a configuration error; the upper bits are dropped
  assign w_unused_cube = ^reg2dp_cube_in_width[X_OFFSET_W-1:WIDTH_W];

  assign w_load     = (r_state == IDLE) && reg2dp_op_load;
  assign w_is_first = (r_split_idx == '0);
  assign w_is_last  = (r_split_idx == r_split_num);
  assign w_valid    = (r_state == ISSUE) && w_below_lim;
  assign w_hs       = w_valid && sched_if.sched2ig_cmd_ready;

  always_comb begin
    w_width_m1 = r_mid_w;
    if (r_split_num == '0)  w_width_m1 = r_cube_w;
    else if (w_is_first)    w_width_m1 = r_first_w;
    else if (w_is_last)     w_width_m1 = r_last_w;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (reg2dp_op_load)          w_state_nxt = ISSUE;
      ISSUE:   if (w_hs && w_is_last)       w_state_nxt = DRAIN;
      DRAIN:   if (r_issued_all && w_zero)  w_state_nxt = DONE;
      DONE:                                 w_state_nxt = IDLE;
      default:                              w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      r_state      <= IDLE;
      r_split_num  <= '0;
      r_split_idx  <= '0;
      r_cube_w     <= '0;
      r_first_w    <= '0;
      r_mid_w      <= '0;
      r_last_w     <= '0;
      r_x_offset   <= '0;
      r_issued_all <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_split_num  <= reg2dp_split_num;
        r_cube_w     <= reg2dp_cube_in_width[WIDTH_W-1:0];
        r_first_w    <= reg2dp_partial_width_in_first;
        r_mid_w      <= reg2dp_partial_width_in_mid;
        r_last_w     <= reg2dp_partial_width_in_last;
        r_split_idx  <= '0;
        r_x_offset   <= '0;
        r_issued_all <= 1'b0;
      end else if (w_hs) begin
        r_split_idx <= r_split_idx + IDX_W'(1);
        // wraps modulo 2^13 by construction
        r_x_offset  <= r_x_offset + {{(X_OFFSET_W-WIDTH_W){1'b0}}, w_width_m1} + X_OFFSET_W'(1);
        if (w_is_last) r_issued_all <= 1'b1;
      end
    end
  end

  nv_nvdla_pdp_rdma_split_cnt #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_split_cnt (
    .i_clk       (nvdla_core_clk),
    .i_rst_n     (nvdla_core_rstn),
    .i_clr       (w_load),
    .i_inc       (w_hs),
    .i_dec       (sched_if.eg2sched_split_done),
    .o_below_lim (w_below_lim),
    .o_zero      (w_zero),
    .o_err       (sched_err)
  );

  // payload is driven to zero whenever no command is offered
  assign sched_if.sched2ig_cmd_valid = w_valid;
  assign sched_if.sched2ig_cmd_pd    = w_valid ?
      pack_cmd_pd(w_is_last, w_is_first, r_split_idx, r_x_offset, w_width_m1) : '0;

  assign sched_busy    = (r_state != IDLE);
  assign sched_op_done = (r_state == DONE);
endmodule

// File: tb/tb_nv_nvdla_pdp_rdma_split_sched.sv
// Self-checking bench for the PDP RDMA split scheduler against a split-list reference model.
module tb_nv_nvdla_pdp_rdma_split_sched;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        op_load;
  logic [7:0]  split_num;
  logic [12:0] cube;
  logic [9:0]  w_first, w_mid, w_last;
  logic        ready, split_done;
  logic        sched_busy, sched_op_done, sched_err;

  nv_nvdla_pdp_rdma_split_sched_if ig_if();
  assign ig_if.sched2ig_cmd_ready  = ready;
  assign ig_if.eg2sched_split_done = split_done;

  nv_nvdla_pdp_rdma_split_sched #(.MAX_OUTSTANDING(MAX_OUT), .CNT_W(3)) dut (
    .nvdla_core_clk                (clk),
    .nvdla_core_rstn               (rstn),
    .reg2dp_op_load                (op_load),
    .reg2dp_split_num              (split_num),
    .reg2dp_cube_in_width          (cube),
    .reg2dp_partial_width_in_first (w_first),
    .reg2dp_partial_width_in_mid   (w_mid),
    .reg2dp_partial_width_in_last  (w_last),
    .sched_if                      (ig_if),
    .sched_busy                    (sched_busy),
    .sched_op_done                 (sched_op_done),
    .sched_err                     (sched_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: phase 0 idle, 1 issuing, 2 draining, 3 done
  int          m_phase, m_out, m_idx, m_n;
  bit          m_err;
  logic [32:0] exp_q[$];
  bit          e_valid, e_busy, e_done;
  logic [32:0] e_pd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_phase = 0; m_out = 0; m_idx = 0; m_n = 0; m_err = 0;
    exp_q.delete();
  endtask

  // expected command list derived from the configuration rules
  task automatic model_load();
    int off;
    logic [9:0] w;
    exp_q.delete();
    off = 0;
    m_n = int'(split_num) + 1;
    for (int i = 0; i < m_n; i++) begin
      if (split_num == 8'd0)  w = cube[9:0];
      else if (i == 0)        w = w_first;
      else if (i == m_n - 1)  w = w_last;
      else                    w = w_mid;
      exp_q.push_back({(i == m_n - 1), (i == 0), 8'(i), 13'(off), w});
      off = (off + int'(w) + 1) % 8192;
    end
    m_idx = 0;
  endtask

  task automatic model_expect();
    e_valid = (m_phase == 1) && (m_out < MAX_OUT);
    e_pd    = e_valid ? exp_q[m_idx] : 33'd0;
    e_busy  = (m_phase != 0);
    e_done  = (m_phase == 3);
  endtask

  task automatic model_advance();
    bit hs;
    hs = e_valid && ready;
    case (m_phase)
      0: if (op_load) begin model_load(); m_phase = 1; end
      1: if (hs && m_idx == m_n - 1) m_phase = 2;
      2: if (m_out == 0) m_phase = 3;
      default: m_phase = 0;
    endcase
    if (split_done && !hs && m_out == 0) m_err = 1;
    if (hs && !split_done) m_out++;
    else if (split_done && !hs && m_out > 0) m_out--;
    if (hs) m_idx++;
  endtask

  function automatic string obs_str();
    return $sformatf("got v=%b pd=%h busy=%b done=%b err=%b, want v=%b pd=%h busy=%b done=%b err=%b",
      ig_if.sched2ig_cmd_valid, ig_if.sched2ig_cmd_pd, sched_busy, sched_op_done, sched_err,
      e_valid, e_pd, e_busy, e_done, m_err);
  endfunction

  task automatic do_reset();
    rstn = 1'b0; op_load = 1'b0; ready = 1'b0; split_done = 1'b0;
    split_num = '0; cube = '0; w_first = '0; w_mid = '0; w_last = '0;
    tick(); tick();
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (ig_if.sched2ig_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", ig_if.sched2ig_cmd_valid); end
    vectors++; if (ig_if.sched2ig_cmd_pd !== 33'd0) begin miscompares++; $display("FAIL reset_pd got %h want 0", ig_if.sched2ig_cmd_pd); end
    vectors++; if (sched_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", sched_busy); end
    vectors++; if (sched_op_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", sched_op_done); end
    vectors++; if (sched_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", sched_err); end
    model_expect(); model_advance(); tick();
  endtask

  task automatic test_single();
    int cyc_hs = -1, cyc_dn = -1, cyc_opd = -1;
    split_num = 8'd0; cube = 13'd99; w_first = 10'd7; w_mid = 10'd8; w_last = 10'd9;
    for (int c = 0; c < 14; c++) begin
      op_load = (c == 0); ready = 1'b1;
      split_done = (cyc_hs >= 0) && (c == cyc_hs + 5);
      if (split_done) cyc_dn = c;
      #1; model_expect();
      vectors++;
      if ({ig_if.sched2ig_cmd_valid, ig_if.sched2ig_cmd_pd, sched_busy, sched_op_done, sched_err} !== {e_valid, e_pd, e_busy, e_done, m_err}) begin
        miscompares++; $display("FAIL single c=%0d %s", c, obs_str());
      end
      if (ig_if.sched2ig_cmd_valid && ready && cyc_hs < 0) begin
        cyc_hs = c;
        vectors++;
        if (ig_if.sched2ig_cmd_pd !== {1'b1, 1'b1, 8'd0, 13'd0, 10'd99}) begin
          miscompares++; $display("FAIL single_pd got %h want %h", ig_if.sched2ig_cmd_pd, {1'b1, 1'b1, 8'd0, 13'd0, 10'd99});
        end
      end
      if (sched_op_done) cyc_opd = c;
      model_advance(); tick();
    end
    op_load = 1'b0; split_done = 1'b0;
    vectors++; if (cyc_hs != 1) begin miscompares++; $display("FAIL single_first_valid got cycle %0d want 1", cyc_hs); end
    vectors++; if (cyc_opd != cyc_dn + 2) begin miscompares++; $display("FAIL single_done_latency got cycle %0d want %0d", cyc_opd, cyc_dn + 2); end
  endtask

  task automatic test_limit();
    int n_valid_early = 0, cyc_opd = -1;
    logic [32:0] third_pd = '0;
    int hs_cnt = 0;
    split_num = 8'd2; cube = 13'd0; w_first = 10'd9; w_mid = 10'd19; w_last = 10'd4;
    for (int c = 0; c < 20; c++) begin
      op_load = (c == 0); ready = 1'b1;
      split_done = (c == 8) || (c == 12) || (c == 14);
      #1; model_expect();
      vectors++;
      if ({ig_if.sched2ig_cmd_valid, ig_if.sched2ig_cmd_pd, sched_busy, sched_op_done, sched_err} !== {e_valid, e_pd, e_busy, e_done, m_err}) begin
        miscompares++; $display("FAIL limit c=%0d %s", c, obs_str());
      end
      if (c >= 1 && c <= 7 && ig_if.sched2ig_cmd_valid) n_valid_early++;
      if (ig_if.sched2ig_cmd_valid && ready) begin
        if (hs_cnt == 2) third_pd = ig_if.sched2ig_cmd_pd;
        hs_cnt++;
      end
      if (sched_op_done) cyc_opd = c;
      model_advance(); tick();
    end
    op_load = 1'b0; split_done = 1'b0;
    vectors++; if (n_valid_early != 2) begin miscompares++; $display("FAIL limit_hold got %0d commands want 2", n_valid_early); end
    vectors++; if (third_pd !== {1'b1, 1'b0, 8'd2, 13'd30, 10'd4}) begin miscompares++; $display("FAIL limit_third_pd got %h want %h", third_pd, {1'b1, 1'b0, 8'd2, 13'd30, 10'd4}); end
    vectors++; if (cyc_opd != 16) begin miscompares++; $display("FAIL limit_done_cycle got %0d want 16", cyc_opd); end
  endtask

  task automatic test_stall();
    logic [32:0] held = '0;
    bit hold = 0;
    int hs_cnt = 0, c = 0;
    split_num = 8'd3; cube = 13'd0;
    w_first = 10'($urandom); w_mid = 10'($urandom); w_last = 10'($urandom);
    do begin
      op_load = (c == 0);
      ready = !(c >= 3 && c <= 5);
      split_done = (c == 2) || ((c >= 6) && (m_out > 0) && ($urandom_range(0, 1) == 1));
      #1; model_expect();
      vectors++;
      if ({ig_if.sched2ig_cmd_valid, ig_if.sched2ig_cmd_pd, sched_busy, sched_op_done, sched_err} !== {e_valid, e_pd, e_busy, e_done, m_err}) begin
        miscompares++; $display("FAIL stall c=%0d %s", c, obs_str());
      end
      if (hold) begin
        vectors++;
        if (ig_if.sched2ig_cmd_valid !== 1'b1 || ig_if.sched2ig_cmd_pd !== held) begin
          miscompares++; $display("FAIL stall_hold c=%0d got v=%b pd=%h want v=1 pd=%h", c, ig_if.sched2ig_cmd_valid, ig_if.sched2ig_cmd_pd, held);
        end
      end
      hold = ig_if.sched2ig_cmd_valid && !ready;
      held = ig_if.sched2ig_cmd_pd;
      if (ig_if.sched2ig_cmd_valid && ready) begin
        vectors++;
        if (ig_if.sched2ig_cmd_pd[30:23] !== 8'(hs_cnt)) begin
          miscompares++; $display("FAIL stall_idx got %0d want %0d", ig_if.sched2ig_cmd_pd[30:23], hs_cnt);
        end
        hs_cnt++;
      end
      model_advance(); tick(); c++;
    end while (m_phase != 0 && c < 200);
    op_load = 1'b0; split_done = 1'b0;
    vectors++; if (hs_cnt != 4 || m_phase != 0) begin miscompares++; $display("FAIL stall_count got %0d commands want 4 (cycles %0d)", hs_cnt, c); end
  endtask

  task automatic test_same_cycle();
    int c = 0;
    split_num = 8'd3; cube = 13'd0; w_first = 10'd1; w_mid = 10'd2; w_last = 10'd3;
    do begin
      op_load = (c == 0);
      ready = (c != 3);
      split_done = (c == 2) || ((c >= 5) && (m_out > 0) && ($urandom_range(0, 2) != 0));
      #1; model_expect();
      vectors++;
      if ({ig_if.sched2ig_cmd_valid, ig_if.sched2ig_cmd_pd, sched_busy, sched_op_done, sched_err} !== {e_valid, e_pd, e_busy, e_done, m_err}) begin
        miscompares++; $display("FAIL same_cycle c=%0d %s", c, obs_str());
      end
      if (c == 3) begin
        vectors++;
        if (ig_if.sched2ig_cmd_valid !== 1'b1 || sched_op_done !== 1'b0) begin
          miscompares++; $display("FAIL same_cycle_cnt got v=%b done=%b want v=1 done=0", ig_if.sched2ig_cmd_valid, sched_op_done);
        end
      end
      model_advance(); tick(); c++;
    end while (m_phase != 0 && c < 300);
    op_load = 1'b0; split_done = 1'b0;
    vectors++; if (m_phase != 0) begin miscompares++; $display("FAIL same_cycle_timeout got phase %0d want 0", m_phase); end
  endtask

  task automatic test_err_idle();
    int c = 0, hs_cnt = 0;
    op_load = 1'b0; ready = 1'b0; split_done = 1'b1;
    #1; model_expect(); model_advance(); tick();
    split_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (sched_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky k=%0d got %b want 1", k, sched_err); end
      model_expect(); model_advance(); tick();
    end
    split_num = 8'd2; cube = 13'd0; w_first = 10'd33; w_mid = 10'd44; w_last = 10'd55;
    do begin
      op_load = (c == 0) || (c == 2) || (c == 3);
      if (c == 2) begin split_num = 8'd7; w_first = 10'd500; w_mid = 10'd600; w_last = 10'd700; end
      ready = ($urandom_range(1, 100) <= 70);
      split_done = (m_out > 0) && ($urandom_range(0, 1) == 1);
      #1; model_expect();
      vectors++;
      if ({ig_if.sched2ig_cmd_valid, ig_if.sched2ig_cmd_pd, sched_busy, sched_op_done, sched_err} !== {e_valid, e_pd, e_busy, e_done, m_err}) begin
        miscompares++; $display("FAIL load_ignored c=%0d %s", c, obs_str());
      end
      if (ig_if.sched2ig_cmd_valid && ready) hs_cnt++;
      model_advance(); tick(); c++;
    end while (m_phase != 0 && c < 300);
    op_load = 1'b0; split_done = 1'b0;
    vectors++; if (hs_cnt != 3) begin miscompares++; $display("FAIL load_ignored_count got %0d commands want 3", hs_cnt); end
  endtask

  task automatic test_reset_drain();
    split_num = 8'd1; cube = 13'd0; w_first = 10'd5; w_mid = 10'd6; w_last = 10'd7;
    for (int c = 0; c < 3; c++) begin
      op_load = (c == 0); ready = 1'b1; split_done = 1'b0;
      #1; model_expect();
      vectors++;
      if ({ig_if.sched2ig_cmd_valid, ig_if.sched2ig_cmd_pd, sched_busy, sched_op_done, sched_err} !== {e_valid, e_pd, e_busy, e_done, m_err}) begin
        miscompares++; $display("FAIL reset_drain c=%0d %s", c, obs_str());
      end
      model_advance(); tick();
    end
    op_load = 1'b0;
    #1;
    vectors++; if (sched_busy !== 1'b1 || ig_if.sched2ig_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL drain_entry got busy=%b v=%b want busy=1 v=0", sched_busy, ig_if.sched2ig_cmd_valid); end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
    #1;
    vectors++; if (ig_if.sched2ig_cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_drain_valid got %b want 0", ig_if.sched2ig_cmd_valid); end
    vectors++; if (ig_if.sched2ig_cmd_pd !== 33'd0) begin miscompares++; $display("FAIL rst_drain_pd got %h want 0", ig_if.sched2ig_cmd_pd); end
    vectors++; if (sched_busy !== 1'b0) begin miscompares++; $display("FAIL rst_drain_busy got %b want 0", sched_busy); end
    vectors++; if (sched_op_done !== 1'b0) begin miscompares++; $display("FAIL rst_drain_done got %b want 0", sched_op_done); end
    vectors++; if (sched_err !== 1'b0) begin miscompares++; $display("FAIL rst_drain_err got %b want 0", sched_err); end
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (sched_op_done !== 1'b0 || sched_busy !== 1'b0) begin miscompares++; $display("FAIL rst_drain_quiet k=%0d got done=%b busy=%b want 0 0", k, sched_op_done, sched_busy); end
      model_expect(); model_advance(); tick();
    end
  endtask

  task automatic test_random();
    for (int op = 0; op < 25; op++) begin
      int c, rp, dp;
      split_num = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      cube = 13'($urandom);
      w_first = ($urandom_range(0, 4) == 0) ? 10'd1023 : 10'($urandom);
      w_mid   = ($urandom_range(0, 4) == 0) ? 10'd1023 : 10'($urandom);
      w_last  = 10'($urandom);
      rp = $urandom_range(30, 100);
      dp = $urandom_range(20, 100);
      op_load = 1'b0; ready = 1'b0;
      split_done = ($urandom_range(0, 19) == 0);
      #1; model_expect();
      vectors++;
      if ({ig_if.sched2ig_cmd_valid, ig_if.sched2ig_cmd_pd, sched_busy, sched_op_done, sched_err} !== {e_valid, e_pd, e_busy, e_done, m_err}) begin
        miscompares++; $display("FAIL rand_idle op=%0d %s", op, obs_str());
      end
      model_advance(); tick();
      c = 0;
      do begin
        op_load = (c == 0) || ($urandom_range(0, 99) < 5);
        if (c != 0 && op_load) begin split_num = 8'($urandom); w_first = 10'($urandom); w_mid = 10'($urandom); end
        ready = ($urandom_range(1, 100) <= rp);
        split_done = (m_out > 0) && ($urandom_range(1, 100) <= dp);
        #1; model_expect();
        vectors++;
        if ({ig_if.sched2ig_cmd_valid, ig_if.sched2ig_cmd_pd, sched_busy, sched_op_done, sched_err} !== {e_valid, e_pd, e_busy, e_done, m_err}) begin
          miscompares++; $display("FAIL rand op=%0d c=%0d %s", op, c, obs_str());
        end
        model_advance(); tick(); c++;
      end while (m_phase != 0 && c < 5000);
      if (m_phase != 0) begin
        vectors++; miscompares++;
        $display("FAIL rand_timeout op=%0d got phase %0d want 0", op, m_phase);
      end
    end
    op_load = 1'b0; split_done = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_limit();
    test_stall();
    test_same_cycle();
    test_err_idle();
    test_reset_drain();
    do_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
